tt_bist_harness: RTL and testbench
==================================

// Module: tt_bist_harness
// PURPOSE
//   On-chip self-test harness for a Tiny Tapeout user project.
//   Generates stimulus vectors on the DUT inputs and compresses DUT responses into a MISR signature.
//   Supports three stimulus modes, a configurable vector count and a configurable DUT pipeline latency.
//   Sits between the top-level pins and tt_um_* in test builds, replacing a fixed hand-wired bench hookup.
// PARAMETERS
//   IN_W      8      stimulus width driven to the DUT (ui_in)
//   OUT_W     8      response width captured from the DUT (uo_out)
//   NUM_VEC   256    vectors per run, >=1; counter width is $clog2(NUM_VEC+1)
//   LAT       0      DUT response latency in cycles (0..15)
//   SEED      1      LFSR seed; a value of 0 is forced to 1
//   LFSR_TAPS 8'hB8  Galois LFSR feedback mask, IN_W bits
//   MISR_TAPS 8'h1D  MISR feedback mask, OUT_W bits
// PORTS
//   clk        in   1      clock
//   rst        in   1      asynchronous reset, active-high
//   ena        in   1      advance enable; low = freeze all state
//   start      in   1      begin a run; sampled only in IDLE or DONE
//   mode       in   2      stimulus mode, latched at start: 0 LFSR, 1 walking-one, 2 count, 3 reserved (acts as count)
//   dut_in     out  IN_W   stimulus vector to the DUT
//   dut_out    in   OUT_W  DUT response
//   busy       out  1      high in RUN and DRAIN
//   done       out  1      high in DONE
//   vec_cnt    out  CW     number of vectors applied so far
//   signature  out  OUT_W  MISR value; held in DONE
//   pass       out  1      golden compare result (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state IDLE, dut_in=0, busy=0, done=0, vec_cnt=0, signature=0, pass=0. Reset mid-run aborts the run.
//   FSM states: IDLE, RUN, DRAIN, DONE.
//     IDLE/DONE, start=1 & ena=1: latch mode, load first vector, clear signature, vec_cnt=0, go to RUN.
//     RUN: drive one vector per ena cycle, vec_cnt++. After vector NUM_VEC-1, go to DRAIN (LAT>0) or DONE (LAT=0).
//     DRAIN: LAT ena cycles, then DONE.
//     DONE: hold outputs until the next start.
//     start in RUN or DRAIN is ignored.
//   Vector k:
//     LFSR mode: v0=SEED; v(k+1) = (v>>1) ^ (v[0] ? LFSR_TAPS : 0).
//     Walking-one mode: 1 << (k mod IN_W).
//     Count mode: k[IN_W-1:0].
//   Capture: a LAT-deep valid pipe tags applied vectors. On each ena edge with a valid tag:
//     sig <= (sig<<1) ^ (sig[OUT_W-1] ? MISR_TAPS : 0) ^ dut_out.
//   Latency: with ena high throughout, done rises NUM_VEC+LAT edges after the start edge.
//   ena=0: FSM, vec_cnt, dut_in, the valid pipe and sig all hold.
//     Bubbles do not enter the MISR, so the signature is independent of ena gaps.
//   dut_in returns to 0 in IDLE. In DRAIN/DONE it holds the last vector.
// CONFIGURATION
//   HARNESS_GOLDEN_CMP_EN defined:
//     Adds parameter GOLDEN (OUT_W bits).
//     pass is registered on entry to DONE as (signature==GOLDEN), and cleared on start.
//   HARNESS_GOLDEN_CMP_EN undefined: pass is tied to 0 and no comparator is built.
// TESTING
//   1. Count mode, IN_W=OUT_W=8, NUM_VEC=4, LAT=0, loopback dut_out=dut_in, start pulse
//      -> dut_in 00,01,02,03; done on the 4th edge; signature=8'h03; vec_cnt=4.
//   2. Walking-one mode, NUM_VEC=9 -> dut_in 01,02,04,08,10,20,40,80,01.
//   3. LFSR mode, SEED=0 -> first vector 8'h01, second 8'hB8; no all-zero vector within 255 vectors.
//   4. Test 1 with LAT=2 and dut_out = dut_in delayed 2 cycles
//      -> signature=8'h03; done on the 6th edge.
//   5. Test 1 with ena low for 3 cycles after vector 1
//      -> dut_in holds 01; done on the 7th edge; signature=8'h03.
//   6. rst pulse during RUN at vec_cnt=2 -> busy=0, done=0, signature=0, dut_in=0.
//      A following start runs cleanly to 8'h03.
//      With HARNESS_GOLDEN_CMP_EN and GOLDEN=8'h03: pass=1; with GOLDEN=8'h04: pass=0.

Source files
------------

// File: rtl/tt_bist_harness.sv
// ============================================================================
// Module   : tt_bist_harness
// Purpose  : On-chip BIST harness that drives stimulus vectors (LFSR, walking-one
//            or count) into a user project and folds its responses into a MISR.
//            Optional golden compare is enabled by defining HARNESS_GOLDEN_CMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_bist_harness #(
    parameter int              IN_W      = 8,
    parameter int              OUT_W     = 8,
    parameter int              NUM_VEC   = 256,
    parameter int              LAT       = 0,
    parameter logic [IN_W-1:0] SEED      = IN_W'(1),
    parameter logic [IN_W-1:0] LFSR_TAPS = IN_W'(8'hB8),
    parameter logic [OUT_W-1:0] MISR_TAPS = OUT_W'(8'h1D),
`ifdef HARNESS_GOLDEN_CMP_EN
    parameter logic [OUT_W-1:0] GOLDEN   = '0,
`endif
    localparam int             CW        = $clog2(NUM_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    vec_cnt,
    output logic [OUT_W-1:0] signature,
    output logic             pass
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IN_W-1:0] c_seed = (SEED == '0) ? IN_W'(1) : SEED;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [IN_W-1:0]  vec_q, vec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic [3:0]       drain_q, drain_d;

    logic [IN_W-1:0]  w_next_vec;
    logic [IN_W-1:0]  w_first_vec;
    logic             w_apply;
    logic             w_capture;

    assign w_apply = (state_q == S_RUN);

    // Valid tags follow each applied vector so only real responses reach the MISR.
    generate
        if (LAT > 0) begin : g_pipe
            logic [LAT-1:0] vld_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else if (ena) begin
                    vld_q <= LAT'({vld_q, w_apply});
                end
            end
            assign w_capture = vld_q[LAT-1];
        end else begin : g_nopipe
            assign w_capture = w_apply;
        end
    endgenerate

    always_comb begin
        w_next_vec = vec_q;
        case (mode_q)
            2'd0:    w_next_vec = (vec_q >> 1) ^ (vec_q[0] ? LFSR_TAPS : '0);
            2'd1:    w_next_vec = (vec_q << 1) | (vec_q >> (IN_W - 1));
            default: w_next_vec = vec_q + IN_W'(1);
        endcase
    end

    always_comb begin
        w_first_vec = '0;
        case (mode)
            2'd0:    w_first_vec = c_seed;
            2'd1:    w_first_vec = IN_W'(1);
            default: w_first_vec = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        sig_d   = sig_q;

        if (w_capture) begin
            sig_d = (sig_q << 1) ^ (sig_q[OUT_W-1] ? MISR_TAPS : '0) ^ dut_out;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d  = mode;
                    vec_d   = w_first_vec;
                    cnt_d   = '0;
                    sig_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_VEC - 1)) begin
                    // The last vector stays on dut_in through DRAIN and DONE.
                    drain_d = '0;
                    state_d = (LAT > 0) ? S_DRAIN : S_DONE;
                end else begin
                    vec_d = w_next_vec;
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'(LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            vec_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 4'd0;
            sig_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            sig_q   <= sig_d;
        end
    end

`ifdef HARNESS_GOLDEN_CMP_EN
    logic pass_q, pass_d;

    always_comb begin
        pass_d = pass_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            pass_d = 1'b0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            pass_d = (sig_d == GOLDEN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else if (ena) begin
            pass_q <= pass_d;
        end
    end

    assign pass = pass_q;
`else
    assign pass = 1'b0;
`endif

    assign dut_in    = vec_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign vec_cnt   = cnt_q;
    assign signature = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_bist_harness.sv
// ============================================================================
// Module   : tb_tt_bist_harness
// Purpose  : Directed self-checking bench for tt_bist_harness (three instances:
//            NUM_VEC=4/LAT=0, NUM_VEC=4/LAT=2, NUM_VEC=255/LAT=0 with SEED=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_bist_harness;

    logic clk;
    int   n_chk;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: count/LFSR, NUM_VEC=4, LAT=0, loopback
    logic       rst_a, ena_a, start_a, busy_a, done_a, pass_a;
    logic [1:0] mode_a;
    logic [7:0] din_a, sig_a;
    logic [2:0] cnt_a;

    // Instance B: NUM_VEC=4, LAT=2, response delayed two clocks
    logic       rst_b, ena_b, start_b, busy_b, done_b, pass_b;
    logic [1:0] mode_b;
    logic [7:0] din_b, sig_b, dly1_b, dly2_b;
    logic [2:0] cnt_b;

    // Instance C: NUM_VEC=255, SEED=0, loopback
    logic       rst_c, ena_c, start_c, busy_c, done_c, pass_c;
    logic [1:0] mode_c;
    logic [7:0] din_c, sig_c;
    logic [7:0] cnt_c;

    always @(posedge clk) begin
        dly1_b <= din_b;
        dly2_b <= dly1_b;
    end

    tt_bist_harness #(
        .NUM_VEC (4),
        .LAT     (0)
`ifdef HARNESS_GOLDEN_CMP_EN
        , .GOLDEN (8'h03)
`endif
    ) u_a (
        .clk(clk), .rst(rst_a), .ena(ena_a), .start(start_a), .mode(mode_a),
        .dut_in(din_a), .dut_out(din_a), .busy(busy_a), .done(done_a),
        .vec_cnt(cnt_a), .signature(sig_a), .pass(pass_a)
    );

    tt_bist_harness #(
        .NUM_VEC (4),
        .LAT     (2)
`ifdef HARNESS_GOLDEN_CMP_EN
        , .GOLDEN (8'h04)
`endif
    ) u_b (
        .clk(clk), .rst(rst_b), .ena(ena_b), .start(start_b), .mode(mode_b),
        .dut_in(din_b), .dut_out(dly2_b), .busy(busy_b), .done(done_b),
        .vec_cnt(cnt_b), .signature(sig_b), .pass(pass_b)
    );

    tt_bist_harness #(
        .NUM_VEC (255),
        .LAT     (0),
        .SEED    (8'h00)
    ) u_c (
        .clk(clk), .rst(rst_c), .ena(ena_c), .start(start_c), .mode(mode_c),
        .dut_in(din_c), .dut_out(din_c), .busy(busy_c), .done(done_c),
        .vec_cnt(cnt_c), .signature(sig_c), .pass(pass_c)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0] walk_exp [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] lfsr_m;
    int         lfsr_bad;
    int         zero_seen;

    initial begin
        n_chk = 0;
        n_err = 0;
        {rst_a, rst_b, rst_c}       = 3'b111;
        {ena_a, ena_b, ena_c}       = 3'b000;
        {start_a, start_b, start_c} = 3'b000;
        mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;

        #2;
        check("rst_dut_in", 32'(din_a), 32'h00);
        check("rst_busy",   32'(busy_a), 32'h0);
        check("rst_done",   32'(done_a), 32'h0);
        check("rst_sig",    32'(sig_a), 32'h00);
        check("rst_cnt",    32'(cnt_a), 32'h0);
        check("rst_pass",   32'(pass_a), 32'h0);

        @(negedge clk);
        {rst_a, rst_b, rst_c} = 3'b000;
        {ena_a, ena_b, ena_c} = 3'b111;

        // Count mode, LAT=0; a start pulse mid-run must be ignored
        mode_a = 2'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t1_busy", 32'(busy_a), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("t1_vec",  32'(din_a), 32'(k));
            check("t1_done", 32'(done_a), 32'h0);
            start_a = (k == 1);
            @(negedge clk);
            start_a = 1'b0;
        end
        check("t1_done_end", 32'(done_a), 32'h1);
        check("t1_busy_end", 32'(busy_a), 32'h0);
        check("t1_sig",      32'(sig_a), 32'h03);
        check("t1_cnt",      32'(cnt_a), 32'h4);
        check("t1_hold_vec", 32'(din_a), 32'h03);
`ifdef HARNESS_GOLDEN_CMP_EN
        check("t1_pass", 32'(pass_a), 32'h1);
`else
        check("t1_pass", 32'(pass_a), 32'h0);
`endif

        // Walking-one mode with wrap after IN_W vectors, then abort by reset
        mode_c = 2'd1; start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("t2_walk", 32'(din_c), 32'(walk_exp[k]));
            @(negedge clk);
        end
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        check("t2_abort_busy", 32'(busy_c), 32'h0);
        check("t2_abort_vec",  32'(din_c), 32'h00);

        // LFSR mode with SEED=0: full 255-vector run against a reference model
        mode_c = 2'd0; start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        lfsr_m = 8'h01; lfsr_bad = 0; zero_seen = 0;
        for (int k = 0; k < 255; k++) begin
            if (k == 0) check("t3_first",  32'(din_c), 32'h01);
            if (k == 1) check("t3_second", 32'(din_c), 32'hB8);
            if (din_c == 8'h00) zero_seen++;
            if (din_c !== lfsr_m) lfsr_bad++;
            lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? 8'hB8 : 8'h00);
            @(negedge clk);
        end
        check("t3_zero_vectors", 32'(zero_seen), 32'd0);
        check("t3_model_diffs",  32'(lfsr_bad), 32'd0);
        check("t3_done",         32'(done_c), 32'h1);
        check("t3_cnt",          32'(cnt_c), 32'd255);

        // LAT=2 with a two-clock response delay
        mode_b = 2'd2; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t4_vec", 32'(din_b), 32'(k));
            @(negedge clk);
        end
        check("t4_drain_busy", 32'(busy_b), 32'h1);
        check("t4_drain_done", 32'(done_b), 32'h0);
        check("t4_drain_vec",  32'(din_b), 32'h03);
        @(negedge clk);
        check("t4_done5", 32'(done_b), 32'h0);
        @(negedge clk);
        check("t4_done6", 32'(done_b), 32'h1);
        check("t4_sig",   32'(sig_b), 32'h03);
        check("t4_pass",  32'(pass_b), 32'h0);

        // ena gap of three cycles after vector 1
        mode_a = 2'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t5_vec0", 32'(din_a), 32'h00);
        @(negedge clk);
        check("t5_vec1", 32'(din_a), 32'h01);
        ena_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t5_hold_vec", 32'(din_a), 32'h01);
            check("t5_hold_cnt", 32'(cnt_a), 32'h1);
        end
        ena_a = 1'b1;
        @(negedge clk);
        check("t5_done5", 32'(done_a), 32'h0);
        @(negedge clk);
        check("t5_done6", 32'(done_a), 32'h0);
        @(negedge clk);
        check("t5_done7", 32'(done_a), 32'h1);
        check("t5_sig",   32'(sig_a), 32'h03);

        // Reset mid-run, then a clean rerun
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_cnt_before", 32'(cnt_a), 32'h2);
        rst_a = 1'b1;
        #1;
        check("t6_busy", 32'(busy_a), 32'h0);
        check("t6_done", 32'(done_a), 32'h0);
        check("t6_sig",  32'(sig_a), 32'h00);
        check("t6_vec",  32'(din_a), 32'h00);
        @(negedge clk);
        rst_a = 1'b0;
        mode_a = 2'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 10 && !done_a; i++) @(negedge clk);
        check("t6_rerun_done", 32'(done_a), 32'h1);
        check("t6_rerun_sig",  32'(sig_a), 32'h03);
`ifdef HARNESS_GOLDEN_CMP_EN
        check("t6_pass", 32'(pass_a), 32'h1);
`else
        check("t6_pass", 32'(pass_a), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
